fifo_tx_serializer: RTL and testbench
=====================================

FIFO_TX_SERIALIZER -- requirements
Module: fifo_tx_serializer

Interface
REQ-001 The block SHALL be parameterized: DWIDTH, 5, width of FIFO word and data bits per frame.
REQ-002 The block SHALL be parameterized: CLKS_PER_BIT, 16, clock cycles per serial bit (legal range 2..65535).
REQ-003 The block SHALL be parameterized: PARITY_EN, 0, 1 = append even-parity bit after data bits.
REQ-004 The block SHALL be parameterized: STOP_BITS, 1, number of stop bits (1 or 2).
REQ-005 The block SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-006 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 The block SHALL have port en, input, 1, permits fetching new words from the FIFO.
REQ-008 The block SHALL have port fifo_empty, input, 1, FIFO empty flag.
REQ-009 The block SHALL have port fifo_data, input, DWIDTH, FIFO data_out; valid on the clock after a sampled fifo_rd_en.
REQ-010 The block SHALL have port fifo_rd_en, output, 1, FIFO read strobe; drives the FIFO rd_en.
REQ-011 The block SHALL have port tx, output, 1, serial line; idles high.
REQ-012 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
REQ-014 IDLE -> FETCH when en=1 and fifo_empty=0 at a rising edge; otherwise remain in IDLE.
REQ-015 fifo_rd_en SHALL be 1 only while in FETCH (exactly one cycle per word); FETCH -> LOAD unconditionally.
REQ-016 In LOAD the shift register SHALL capture fifo_data at the rising edge and the FSM SHALL go to START.
REQ-017 tx SHALL be a registered output: 0 for START, shift_reg[0] for DATA (LSB first), even parity of the captured word for PARITY, and 1 in STOP, IDLE, FETCH and LOAD.
REQ-018 Each of START, each DATA bit, PARITY and each stop bit SHALL last exactly CLKS_PER_BIT cycles, timed by a baud counter that reloads at each bit boundary.
REQ-019 A bit counter SHALL count DATA bits 0..DWIDTH-1; DATA -> PARITY if PARITY_EN=1, else DATA -> STOP.
REQ-020 STOP SHALL last STOP_BITS*CLKS_PER_BIT cycles; at the end -> FETCH if en=1 and fifo_empty=0, else -> IDLE.
REQ-021 Frame length SHALL be (1+DWIDTH+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles; the inter-frame gap for back-to-back words SHALL be exactly 2 tx-high cycles (FETCH, LOAD).
REQ-022 Deasserting en mid-frame SHALL NOT abort the frame; only the next fetch is suppressed.
REQ-023 fifo_rd_en SHALL never assert while fifo_empty=1 was sampled at the FETCH-entry edge; words SHALL NOT be dropped or duplicated.
REQ-024 fifo_empty or fifo_data changes outside FETCH/LOAD SHALL have no effect on the frame in progress.

Reset
REQ-025 While rst=1, asynchronously: state=IDLE, tx=1, fifo_rd_en=0, busy=0, baud and bit counters=0, shift register=0.
REQ-026 Reset asserted mid-frame SHALL discard the word in flight; after release, operation SHALL resume from IDLE with the next FIFO word.
REQ-027 The first fetch after reset release SHALL occur no earlier than the first rising edge with rst=0.

Verification (DWIDTH=5, CLKS_PER_BIT=4, PARITY_EN=1, STOP_BITS=1 unless noted)
REQ-028 Reset: assert rst with en=1 and fifo_empty=0 -> tx=1, busy=0, fifo_rd_en=0 throughout.
REQ-029 Single word 5'b10110 -> one 1-cycle fifo_rd_en pulse; tx = 0,0,1,1,0,1,1(parity),1, each 4 cycles, for a 32-cycle frame; then busy=0.
REQ-030 Three words queued (5'b00001, 5'b11111, 5'b01010), en=1 -> three rd_en pulses; frames separated by exactly 2 tx-high cycles after each stop bit; parity bits 1, 1, 0.
REQ-031 fifo_empty=1 and en=1 for 100 cycles -> fifo_rd_en never asserts; tx=1; busy=0.
REQ-032 rst pulsed during DATA bit 2 -> tx=1 and busy=0 in the same cycle; after release with a word queued, a complete fresh 32-cycle frame follows.
REQ-033 en dropped during the START bit with words still queued -> current frame completes; no further rd_en; FSM returns to IDLE.

Source files
------------

// File: rtl/fifo_tx_serializer.sv
// fifo_tx_serializer: pulls words from a show-ahead-less FIFO and sends each
// one as an asynchronous serial frame (start, LSB-first data, optional even
// parity, stop bits). tx is registered so the line never glitches.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | line high, waiting for en=1 with a non-empty FIFO
// FETCH  | one-cycle FIFO read strobe
// LOAD   | FIFO data now valid; capture into shift register
// START  | start bit (tx=0)
// DATA   | data bits, LSB first
// PARITY | even parity of the captured word (only if PARITY_EN=1)
// STOP   | STOP_BITS stop bits (tx=1), then fetch the next word or idle

module fifo_tx_serializer #(
    parameter int DWIDTH       = 5,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic              tx,
    output logic              busy
);

    localparam int BAUD_W = 16;
    // Bit counter serves both data bits and stop bits; stop count is <= 2.
    localparam int BIT_W  = (DWIDTH > 2) ? $clog2(DWIDTH) : 1;

    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  LAST_DATA   = BIT_W'(DWIDTH - 1);
    localparam logic [BIT_W-1:0]  LAST_STOP   = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [BAUD_W-1:0]   baud_cnt;
    logic [BAUD_W-1:0]   baud_nxt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [BIT_W-1:0]    bit_nxt;
    logic [DWIDTH-1:0]   shift_reg;
    logic [DWIDTH-1:0]   shift_nxt;
    logic [DWIDTH-1:0]   shift_dn;
    logic                parity_reg;
    logic                parity_nxt;
    logic                tx_nxt;
    logic                baud_done;
    logic                fetch_ok;

    assign baud_done = (baud_cnt == '0);
    assign fetch_ok  = en && !fifo_empty;
    assign shift_dn  = shift_reg >> 1;

    // Strobe and busy decode straight from the state register, so both
    // follow reset asynchronously and the strobe is exactly one cycle wide.
    assign fifo_rd_en = (state == FETCH);
    assign busy       = (state != IDLE);

    // State, timers, datapath and the registered line output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tx         <= 1'b1;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_reg <= 1'b0;
        end else begin
            state      <= state_nxt;
            tx         <= tx_nxt;
            baud_cnt   <= baud_nxt;
            bit_cnt    <= bit_nxt;
            shift_reg  <= shift_nxt;
            parity_reg <= parity_nxt;
        end
    end

    // Next-state logic; tx_nxt is the line level for the state being entered.
    always_comb begin
        state_nxt  = state;
        baud_nxt   = baud_cnt;
        bit_nxt    = bit_cnt;
        shift_nxt  = shift_reg;
        parity_nxt = parity_reg;
        tx_nxt     = 1'b1;

        case (state)
            IDLE: begin
                if (fetch_ok) begin
                    state_nxt = FETCH;
                end
            end

            FETCH: begin
                state_nxt = LOAD;
            end

            LOAD: begin
                shift_nxt  = fifo_data;
                parity_nxt = ^fifo_data;
                baud_nxt   = BAUD_RELOAD;
                bit_nxt    = '0;
                state_nxt  = START;
                tx_nxt     = 1'b0;
            end

            START: begin
                tx_nxt = 1'b0;
                if (baud_done) begin
                    baud_nxt  = BAUD_RELOAD;
                    state_nxt = DATA;
                    tx_nxt    = shift_reg[0];
                end else begin
                    baud_nxt = baud_cnt - 1'b1;
                end
            end

            DATA: begin
                tx_nxt = shift_reg[0];
                if (baud_done) begin
                    baud_nxt = BAUD_RELOAD;
                    if (bit_cnt == LAST_DATA) begin
                        bit_nxt = '0;
                        if (PARITY_EN != 0) begin
                            state_nxt = PARITY;
                            tx_nxt    = parity_reg;
                        end else begin
                            state_nxt = STOP;
                            tx_nxt    = 1'b1;
                        end
                    end else begin
                        bit_nxt   = bit_cnt + 1'b1;
                        shift_nxt = shift_dn;
                        tx_nxt    = shift_dn[0];
                    end
                end else begin
                    baud_nxt = baud_cnt - 1'b1;
                end
            end

            PARITY: begin
                tx_nxt = parity_reg;
                if (baud_done) begin
                    baud_nxt  = BAUD_RELOAD;
                    bit_nxt   = '0;
                    state_nxt = STOP;
                    tx_nxt    = 1'b1;
                end else begin
                    baud_nxt = baud_cnt - 1'b1;
                end
            end

            STOP: begin
                if (baud_done) begin
                    if (bit_cnt == LAST_STOP) begin
                        bit_nxt   = '0;
                        state_nxt = fetch_ok ? FETCH : IDLE;
                    end else begin
                        bit_nxt  = bit_cnt + 1'b1;
                        baud_nxt = BAUD_RELOAD;
                    end
                end else begin
                    baud_nxt = baud_cnt - 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_tx_serializer.sv
// Directed bench for fifo_tx_serializer (DWIDTH=5, CLKS_PER_BIT=4,
// PARITY_EN=1, STOP_BITS=1). A queue stands in for the FIFO; its data
// appears the cycle after a sampled read strobe. Outputs are sampled on
// the falling edge.

module tb_fifo_tx_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       fifo_empty;
    logic [4:0] fifo_data;
    logic       fifo_rd_en;
    logic       tx;
    logic       busy;

    int errors = 0;
    int checks = 0;

    logic [4:0] fifo_q[$];
    logic       pend = 1'b0;
    int         underflow = 0;

    logic s_tx;
    logic s_busy;
    logic s_rd;

    fifo_tx_serializer #(
        .DWIDTH(5),
        .CLKS_PER_BIT(4),
        .PARITY_EN(1),
        .STOP_BITS(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .fifo_empty(fifo_empty),
        .fifo_data(fifo_data),
        .fifo_rd_en(fifo_rd_en),
        .tx(tx),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, let the FIFO model answer a read
    // strobe seen in the previous cycle, then sample the DUT outputs.
    task automatic cyc();
        @(negedge clk);
        if (pend) begin
            if (fifo_q.size() == 0) underflow++;
            else fifo_data = fifo_q.pop_front();
            pend = 1'b0;
        end
        fifo_empty = (fifo_q.size() == 0);
        s_tx   = tx;
        s_busy = busy;
        s_rd   = fifo_rd_en;
        if (s_rd) pend = 1'b1;
    endtask

    task automatic push(input logic [4:0] w);
        fifo_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic wait_rd(input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            cyc();
            if (s_rd) found = 1'b1;
        end
        chk("rd_pulse_seen", 32'(found), 1);
    endtask

    // Called right after the FETCH cycle was sampled. pat holds the expected
    // line level of each of the 8 bit slots, slot 0 (start) in bit 0.
    task automatic check_frame(input string name, input logic [7:0] pat, input int drop_at);
        int rd_bad = 0;
        int busy_bad = 0;
        cyc();
        chk({name, "_load_tx"}, 32'(s_tx), 1);
        chk({name, "_load_rd"}, 32'(s_rd), 0);
        chk({name, "_load_busy"}, 32'(s_busy), 1);
        for (int i = 0; i < 32; i++) begin
            cyc();
            chk($sformatf("%s_tx_slot%0d_c%0d", name, i / 4, i % 4), 32'(s_tx), 32'(pat[i / 4]));
            if (s_rd) rd_bad++;
            if (!s_busy) busy_bad++;
            if (i == drop_at) en = 1'b0;
        end
        chk({name, "_frame_rd_quiet"}, 32'(rd_bad), 0);
        chk({name, "_frame_busy"}, 32'(busy_bad), 0);
    endtask

    initial begin
        int bad_rd;
        int bad_tx;
        int bad_busy;

        rst        = 1'b1;
        en         = 1'b1;
        fifo_data  = 5'b00000;
        fifo_empty = 1'b1;
        push(5'b10110);

        // Reset held with work pending
        #1;
        chk("rst_t0_tx", 32'(tx), 1);
        chk("rst_t0_busy", 32'(busy), 0);
        chk("rst_t0_rd", 32'(fifo_rd_en), 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("rst_hold_tx", 32'(s_tx), 1);
            chk("rst_hold_busy", 32'(s_busy), 0);
            chk("rst_hold_rd", 32'(s_rd), 0);
        end

        // Single word 10110 -> 0,0,1,1,0,1,parity 1,stop 1
        rst = 1'b0;
        wait_rd(4);
        check_frame("w10110", 8'b1110_1100, -1);
        cyc();
        chk("single_end_busy", 32'(s_busy), 0);
        chk("single_end_rd", 32'(s_rd), 0);
        chk("single_end_tx", 32'(s_tx), 1);

        // Empty FIFO with en=1 for 100 cycles
        bad_rd = 0; bad_tx = 0; bad_busy = 0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (s_rd) bad_rd++;
            if (s_tx !== 1'b1) bad_tx++;
            if (s_busy) bad_busy++;
        end
        chk("empty_rd_count", 32'(bad_rd), 0);
        chk("empty_tx_low_count", 32'(bad_tx), 0);
        chk("empty_busy_count", 32'(bad_busy), 0);

        // Three words back to back; gap is FETCH+LOAD after each stop bit
        push(5'b00001);
        push(5'b11111);
        push(5'b01010);
        wait_rd(4);
        check_frame("w00001", 8'b1100_0010, -1);
        cyc();
        chk("b2b1_fetch_rd", 32'(s_rd), 1);
        chk("b2b1_fetch_tx", 32'(s_tx), 1);
        check_frame("w11111", 8'b1111_1110, -1);
        cyc();
        chk("b2b2_fetch_rd", 32'(s_rd), 1);
        chk("b2b2_fetch_tx", 32'(s_tx), 1);
        check_frame("w01010", 8'b1001_0100, -1);
        cyc();
        chk("b2b_end_busy", 32'(s_busy), 0);
        chk("b2b_end_rd", 32'(s_rd), 0);
        chk("b2b_queue_left", 32'(fifo_q.size()), 0);

        // Reset during DATA bit 2 of 11001; 00110 must follow as a fresh frame
        push(5'b11001);
        push(5'b00110);
        wait_rd(4);
        cyc();
        for (int i = 0; i < 14; i++) cyc();
        chk("pre_rst_tx_bit2", 32'(s_tx), 0);
        chk("pre_rst_busy", 32'(s_busy), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_tx", 32'(tx), 1);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_rd", 32'(fifo_rd_en), 0);
        for (int i = 0; i < 3; i++) cyc();
        rst = 1'b0;
        wait_rd(4);
        check_frame("w00110", 8'b1000_1100, -1);
        cyc();
        chk("post_rst_end_busy", 32'(s_busy), 0);

        // en dropped during START with two words still queued
        push(5'b10011);
        push(5'b01100);
        push(5'b11110);
        wait_rd(4);
        check_frame("w10011", 8'b1110_0110, 1);
        cyc();
        chk("endrop_idle_busy", 32'(s_busy), 0);
        chk("endrop_idle_rd", 32'(s_rd), 0);
        bad_rd = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (s_rd) bad_rd++;
        end
        chk("endrop_no_fetch", 32'(bad_rd), 0);
        chk("endrop_queue_left", 32'(fifo_q.size()), 2);

        chk("fifo_underflow", 32'(underflow), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
